// File: rtl/past_cause_checker_pkg.sv
// past_chk_pkg: shared types and helpers for the past-cause checker.
// Holds the mode enum, default history depth and a saturating adder.
package past_chk_pkg;

  typedef enum logic {
    CHK_EXACT,
    CHK_WINDOW
  } chk_mode_e;

  localparam int unsigned HIST_DEPTH_DEF = 3;
  localparam int unsigned SAT_MAX_W      = 32;

  localparam logic [SAT_MAX_W:0] SAT_ONE = 1;

  // Adds a+b and clamps to 2^w-1; w may be 1..SAT_MAX_W.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    lim = (SAT_ONE << w) - SAT_ONE;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > lim) begin
      return lim[SAT_MAX_W-1:0];
    end
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/past_cause_checker_if.sv
// past_chk_if: check inputs and result outputs of the checker.
// PAST_CHK_TIMESTAMP_EN adds first_fail_cyc.
interface past_chk_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              mode;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] cause;
  logic              clr;
  logic [NUM_CH-1:0] pass_pulse;
  logic [NUM_CH-1:0] fail_pulse;
  logic              err_sticky;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              first_fail_vld;
  logic [CH_W-1:0]   first_fail_ch;
`ifdef PAST_CHK_TIMESTAMP_EN
  logic [31:0]       first_fail_cyc;
`endif

  modport master (
    output mode, ch_en, trig, cause, clr,
    input  pass_pulse, fail_pulse, err_sticky,
    input  pass_cnt, fail_cnt,
`ifdef PAST_CHK_TIMESTAMP_EN
    input  first_fail_cyc,
`endif
    input  first_fail_vld, first_fail_ch
  );

  modport slave (
    input  mode, ch_en, trig, cause, clr,
    output pass_pulse, fail_pulse, err_sticky,
    output pass_cnt, fail_cnt,
`ifdef PAST_CHK_TIMESTAMP_EN
    output first_fail_cyc,
`endif
    output first_fail_vld, first_fail_ch
  );

endinterface

// File: rtl/past_cause_checker_hist.sv
// past_hist_shreg: per-channel cause history, hist[k] = cause k cycles ago.
// Exposes the EXACT tap and the OR over the look-back window.
module past_hist_shreg #(
  parameter int unsigned DELAY = 3,
  parameter int unsigned WIN   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic tap,
  output logic win_or
);
  localparam int unsigned DEPTH = DELAY + WIN - 1;

  // Bit k-1 of the register holds hist[k].
  localparam logic [DEPTH-1:0] WMASK =
    DEPTH'({WIN{1'b1}}) << (DELAY - 1);

  logic [DEPTH-1:0] hist_d;
  logic [DEPTH-1:0] hist_q;

  if (DEPTH > 1) begin : g_shift
    always_comb begin
      hist_d = {hist_q[DEPTH-2:0], din};
    end
  end else begin : g_single
    always_comb begin
      hist_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign tap    = hist_q[DELAY-1];
  assign win_or = |(hist_q & WMASK);

endmodule

// File: rtl/past_cause_checker.sv
// past_cause_checker: multi-channel "effect implies past cause" monitor.
// Define PAST_CHK_TIMESTAMP_EN to add the first-fail cycle timestamp.
module past_cause_checker
  import past_chk_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DELAY  = HIST_DEPTH_DEF,
  parameter int unsigned WIN    = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  past_chk_if.slave mon
);
  localparam int unsigned DEPTH = DELAY + WIN - 1;
  localparam int unsigned WU_W  = $clog2(DEPTH + 1);
  localparam int unsigned CH_W  =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] tap;
  logic [NUM_CH-1:0] win_or;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] pass_d, pass_q;
  logic [NUM_CH-1:0] fail_d, fail_q;
  logic [CNT_W-1:0]  pass_cnt_d, pass_cnt_q;
  logic [CNT_W-1:0]  fail_cnt_d, fail_cnt_q;
  logic [CNT_W-1:0]  pass_base, fail_base;
  logic [WU_W-1:0]   wu_d, wu_q;
  logic              warm;
  logic              err_d, err_q;
  logic              ffv_d, ffv_q, ffv_base;
  logic              ff_cap;
  logic [CH_W-1:0]   ffc_d, ffc_q, ffc_base;
  logic [CH_W-1:0]   low_ch;
  logic [31:0]       n_pass, n_fail;
  chk_mode_e         mode_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    past_hist_shreg #(
      .DELAY (DELAY),
      .WIN   (WIN)
    ) u_hist (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (mon.cause[i]),
      .tap    (tap[i]),
      .win_or (win_or[i])
    );
  end

  // Warm once every history tap has seen a post-reset sample.
  always_comb begin
    warm = (wu_q == WU_W'(DEPTH));
    wu_d = warm ? wu_q : wu_q + WU_W'(1);
  end

  always_comb begin
    mode_e = chk_mode_e'(mon.mode);
    hit    = (mode_e == CHK_WINDOW) ? win_or : tap;
    fire   = mon.trig & mon.ch_en & {NUM_CH{warm}};
    pass_d = fire & hit;
    fail_d = fire & ~hit;
  end

  always_comb begin
    n_pass = '0;
    n_fail = '0;
    low_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_pass = n_pass + 32'(pass_d[i]);
      n_fail = n_fail + 32'(fail_d[i]);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_d[i]) begin
        low_ch = CH_W'(i);
      end
    end
  end

  // clr wipes the old state; this cycle's results still land.
  always_comb begin
    pass_base  = mon.clr ? '0 : pass_cnt_q;
    fail_base  = mon.clr ? '0 : fail_cnt_q;
    ffv_base   = mon.clr ? 1'b0 : ffv_q;
    ffc_base   = mon.clr ? '0 : ffc_q;
    pass_cnt_d = CNT_W'(sat_add(32'(pass_base),
                                n_pass, CNT_W));
    fail_cnt_d = CNT_W'(sat_add(32'(fail_base),
                                n_fail, CNT_W));
    err_d      = (mon.clr ? 1'b0 : err_q) | (|fail_d);
    ff_cap     = !ffv_base && (|fail_d);
    ffv_d      = ffv_base | ff_cap;
    ffc_d      = ff_cap ? low_ch : ffc_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wu_q       <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ffv_q      <= 1'b0;
      ffc_q      <= '0;
    end else begin
      wu_q       <= wu_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ffc_q      <= ffc_d;
    end
  end

  assign mon.pass_pulse     = pass_q;
  assign mon.fail_pulse     = fail_q;
  assign mon.pass_cnt       = pass_cnt_q;
  assign mon.fail_cnt       = fail_cnt_q;
  assign mon.err_sticky     = err_q;
  assign mon.first_fail_vld = ffv_q;
  assign mon.first_fail_ch  = ffc_q;

`ifdef PAST_CHK_TIMESTAMP_EN
  logic [31:0] cyc_d, cyc_q;
  logic [31:0] ffcyc_d, ffcyc_q;

  always_comb begin
    cyc_d   = mon.clr ? '0 : cyc_q + 32'd1;
    ffcyc_d = mon.clr ? '0 : ffcyc_q;
    if (ff_cap) begin
      ffcyc_d = mon.clr ? '0 : cyc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      ffcyc_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      ffcyc_q <= ffcyc_d;
    end
  end

  assign mon.first_fail_cyc = ffcyc_q;
`endif

endmodule
